noise_lfsr_multi: RTL and testbench
===================================

# noise_lfsr_multi

Parametrised successor noise channel for the SN76489-compatible PSG. It replaces the fixed-variant noise generator with one block that selects its LFSR geometry (SG-1000/BBC/Coleco, SMS/Genesis/GG, Tandy 1000) at control-write time. It owns a prescaled period counter, restarts the LFSR on every noise-register write, and emits a shift strobe for the mixer/attenuator stage. It sits beside the three tone channels and consumes tone channel 3's period or its output flip-flop.

## Interface
Parameters:
- COUNTER_BITS, 10: width of `tone_freq`.
- DEFAULT_VARIANT, 2'b00: LFSR variant loaded at reset.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: synchronous active-low reset.
- enable  in  1: clock-enable strobe, one pulse per master/16 tick.
- control_wr  in  1: noise-register write strobe; one cycle.
- control  in  3: {FB, NF1, NF0}; sampled on `control_wr`.
- variant  in  2: LFSR variant; sampled on `control_wr`.
- tone_freq  in  COUNTER_BITS: tone 3 period; read live.
- tone3_out  in  1: tone 3 output flip-flop; used only under the macro.
- out  out  1: noise bit, equal to `lfsr[0]`.
- shift_strobe  out  1: one-cycle pulse in the cycle the shifted value first appears on `out`.

## Operation
- **State.** The block holds:
  - `ctl_q[2:0]` and `var_q[1:0]`, loaded on `control_wr`;
  - a 16-bit `lfsr`;
  - a down-counter `cnt` of COUNTER_BITS+2 bits;
  - `t3_q`, a registered copy of `tone3_out`.
- **Variants.**
  - 00: 15-bit register; taps 0,1; feedback into bit 14; seed 0x4000.
  - 01: 16-bit register; taps 0,3; feedback into bit 15; seed 0x8000.
  - 10: 15-bit register; taps 0,4; feedback into bit 14; seed 0x4000.
  - 11: reserved; behaves exactly as 00.
  - For 15-bit variants, bit 15 is held at 0.
- **Feedback.**
  - FB=1 (white): fb = lfsr[tapA] ^ lfsr[tapB].
  - FB=0 (periodic): fb = lfsr[0].
  - Shift: lfsr <= {fb at top bit, lfsr[top:1]}.
- **Period P, selected by NF:**
  - 00: 32.
  - 01: 64.
  - 10: 128.
  - 11: 2 × tone_freq. If tone_freq = 0, P = 2^(COUNTER_BITS+1), i.e. 2048 at the default width.
  - Arithmetic is done in COUNTER_BITS+2 bits; no truncation.
- **Counter.**
  - On an `enable` cycle with cnt == 0: shift the LFSR and reload cnt = P−1.
  - On an `enable` cycle with cnt ≠ 0: cnt decrements.
  - When `enable` is low, cnt and lfsr hold.
- **Control write.** On `control_wr`, the block loads `ctl_q` and `var_q`, sets lfsr to the new variant's seed, and sets cnt to the new P−1. The first shift therefore comes after exactly P enables.
- **Priority:** rst_n low > control_wr > shift.
  - If a control write coincides with a shift, no shift occurs.
  - A control write is not gated by `enable`.
- **tone_freq changes** (NF=11) take effect at the next reload, not mid-count.
- **Invariant:** the shift is invertible, so lfsr is never 0 in normal operation. The bench asserts this.

## Timing
- **Reset values:**
  - ctl_q = 000, var_q = DEFAULT_VARIANT;
  - lfsr = seed of DEFAULT_VARIANT, so out = 0;
  - cnt = 31, t3_q = 0, shift_strobe = 0.
- **Latency to `out`:** the shift edge updates `out` one cycle later. `shift_strobe` is registered and asserts in that same cycle, for exactly one cycle.
- **Control-write latency:** `out` shows the seed's bit 0 (0) in the cycle after `control_wr`.
- **No enable:** `out` is stable between shift edges; `shift_strobe` never asserts without a preceding enabled shift or tone3 edge.

## Configuration
- NOISE_TONE3_SYNC_EN
  - Defined: with NF=11, the counter is bypassed. A shift occurs on any cycle where tone3_out & ~t3_q, independent of `enable`. `control_wr` still has priority. cnt holds, and is reloaded on a switch back to NF≠11.
  - Undefined: `tone3_out` and `t3_q` are unused and optimised away. NF=11 uses the internal 2 × tone_freq counter as described in Operation.

## Test plan
- **White, variant 00.** Reset; write control=100, variant=00; enable every cycle.
  - The first shift_strobe comes 32 cycles after the write.
  - out first goes high after the 14th shift.
  - lfsr returns to 0x4000 after exactly 32767 shifts.
- **Periodic, variants 00 and 01.**
  - Variant 00, control=000: out is high for 1 of every 15 shifts, a period of 480 enables.
  - Variant 01: out is high for 1 of every 16 shifts; the first high comes after 15 shifts.
- **Restart.**
  - A control_wr mid-stream sets lfsr to the seed and resets the next shift to P enables later.
  - A control_wr in the same cycle as cnt==0 with enable high produces no shift_strobe.
- **NF=11 without the macro.**
  - tone_freq=5: a shift every 10 enables.
  - tone_freq=0: a shift every 2048 enables.
  - With enable high only every 16th cycle, shift intervals scale ×16.
- **NF=11 with NOISE_TONE3_SYNC_EN.** Toggle tone3_out every 7 cycles.
  - Exactly one shift per rising edge; none on falling edges.
  - tone_freq is ignored.
- **Reset mid-run.** rst_n low for one cycle.
  - Next cycle: out=0, shift_strobe=0, lfsr equals the DEFAULT_VARIANT seed, cnt=31.
  - A control_wr asserted during reset is ignored.

Source files
------------

// File: rtl/noise_lfsr_multi.sv
// noise_lfsr_multi
// Multi-variant SN76489-family noise channel. Selects the LFSR geometry
// (SG-1000/BBC/Coleco, SMS/Genesis/GG, Tandy 1000) on every noise-register
// write, runs a prescaled period counter and flags each shift for the mixer.
//
// Optional feature macro: NOISE_TONE3_SYNC_EN
//   When defined and NF=11, the LFSR shifts on each rising edge of tone3_out
//   instead of on the internal 2*tone_freq counter.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   enable       clock-enable tick (master/16)
//   control_wr   noise-register write strobe
//   control      {FB, NF1, NF0}, sampled on control_wr
//   variant      LFSR variant, sampled on control_wr
//   tone_freq    tone 3 period, read live at each reload
//   tone3_out    tone 3 output flip-flop (used only with the macro)
//   out          noise bit (lfsr[0])
//   shift_strobe one-cycle pulse when a shifted value first shows on out
module noise_lfsr_multi #(
    parameter int unsigned COUNTER_BITS    = 10,
    parameter logic [1:0]  DEFAULT_VARIANT = 2'b00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    control_wr,
    input  logic [2:0]              control,
    input  logic [1:0]              variant,
    input  logic [COUNTER_BITS-1:0] tone_freq,
    input  logic                    tone3_out,
    output logic                    out,
    output logic                    shift_strobe
);

    localparam int unsigned CW     = COUNTER_BITS + 2;
    localparam logic [15:0] SEED15 = 16'h4000;
    localparam logic [15:0] SEED16 = 16'h8000;

    logic [2:0]    ctl_q;
    logic [1:0]    var_q;
    logic [15:0]   lfsr;
    logic [CW-1:0] cnt;
    logic          shift_c;
    logic          count_en_c;

    // Seed for a variant; only the 16-bit variant starts from bit 15.
    function automatic logic [15:0] seed_of(input logic [1:0] v);
        return (v == 2'b01) ? SEED16 : SEED15;
    endfunction

    // Counter reload value P-1 for a given NF selection.
    function automatic logic [CW-1:0] reload_of(input logic [1:0] nf,
                                                input logic [COUNTER_BITS-1:0] tf);
        logic [CW-1:0] p;
        case (nf)
            2'b00:   p = CW'(32);
            2'b01:   p = CW'(64);
            2'b10:   p = CW'(128);
            // tone_freq of zero acts as the full 2^COUNTER_BITS tone period
            default: p = (tf == '0) ? (CW'(1) << (COUNTER_BITS + 1)) : (CW'(tf) << 1);
        endcase
        return p - CW'(1);
    endfunction

    // One LFSR step; 15-bit variants keep bit 15 at zero.
    function automatic logic [15:0] shift_of(input logic [15:0] l,
                                             input logic [1:0]  v,
                                             input logic        white);
        logic tap_b;
        logic fb;
        case (v)
            2'b01:   tap_b = l[3];
            2'b10:   tap_b = l[4];
            default: tap_b = l[1];
        endcase
        fb = white ? (l[0] ^ tap_b) : l[0];
        if (v == 2'b01) begin
            return {fb, l[15:1]};
        end
        return {1'b0, fb, l[14:1]};
    endfunction

`ifdef NOISE_TONE3_SYNC_EN
    logic t3_q;

    // Edge detector history for tone 3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t3_q <= 1'b0;
        end else begin
            t3_q <= tone3_out;
        end
    end

    // NF=11 bypasses the counter and follows tone 3 rising edges.
    always_comb begin
        shift_c    = 1'b0;
        count_en_c = 1'b0;
        if (ctl_q[1:0] == 2'b11) begin
            shift_c = tone3_out & ~t3_q;
        end else begin
            count_en_c = enable;
            shift_c    = enable && (cnt == '0);
        end
    end
`else
    logic unused_tone3;
    assign unused_tone3 = tone3_out;

    // Shift when an enabled tick finds the counter expired.
    always_comb begin
        shift_c    = 1'b0;
        count_en_c = enable;
        if (enable && (cnt == '0)) begin
            shift_c = 1'b1;
        end
    end
`endif

    // Control write beats shift; a write restarts the LFSR and the period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_q        <= 3'b000;
            var_q        <= DEFAULT_VARIANT;
            lfsr         <= seed_of(DEFAULT_VARIANT);
            cnt          <= CW'(31);
            shift_strobe <= 1'b0;
        end else begin
            shift_strobe <= 1'b0;
            if (control_wr) begin
                ctl_q <= control;
                var_q <= variant;
                lfsr  <= seed_of(variant);
                cnt   <= reload_of(control[1:0], tone_freq);
            end else begin
                if (shift_c) begin
                    lfsr         <= shift_of(lfsr, var_q, ctl_q[2]);
                    shift_strobe <= 1'b1;
                end
                if (count_en_c) begin
                    cnt <= (cnt == '0) ? reload_of(ctl_q[1:0], tone_freq) : (cnt - CW'(1));
                end
            end
        end
    end

    assign out = lfsr[0];

endmodule

// File: tb/tb_noise_lfsr_multi.sv
// Bench for noise_lfsr_multi: directed test-plan scenarios plus a random run,
// all checked every cycle against an arithmetic reference model.
module tb_noise_lfsr_multi;

    localparam int unsigned CB = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          control_wr;
    logic [2:0]    control;
    logic [1:0]    variant;
    logic [CB-1:0] tone_freq;
    logic          tone3_out;
    logic          out;
    logic          shift_strobe;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_ctl, m_var, m_lfsr, m_wait;
    bit m_strobe, m_t3;

    int cyc       = 0;
    int en_div    = 1;
    bit rnd_en    = 0;
    bit t3_toggle = 0;

    noise_lfsr_multi #(.COUNTER_BITS(CB), .DEFAULT_VARIANT(2'b00)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .control_wr(control_wr),
        .control(control), .variant(variant), .tone_freq(tone_freq),
        .tone3_out(tone3_out), .out(out), .shift_strobe(shift_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int seed(input int v);
        return (v == 1) ? 'h8000 : 'h4000;
    endfunction

    function automatic int period(input int nf, input int tf);
        case (nf)
            0: return 32;
            1: return 64;
            2: return 128;
            default: return (tf == 0) ? 2048 : 2 * tf;
        endcase
    endfunction

    function automatic int next_lfsr(input int l, input int v, input bit white);
        int width, tap, fb;
        width = (v == 1) ? 16 : 15;
        tap   = (v == 1) ? 3 : ((v == 2) ? 4 : 1);
        fb    = white ? ((l ^ (l >> tap)) & 1) : (l & 1);
        return (l >> 1) | (fb << (width - 1));
    endfunction

    // m_wait = enabled ticks remaining until the next shift
    task automatic model_step();
        bit sh;
        sh = 0;
        if (!rst_n) begin
            m_ctl = 0; m_var = 0; m_lfsr = seed(0); m_wait = 32;
            m_strobe = 0; m_t3 = 0;
            return;
        end
        if (control_wr) begin
            m_ctl  = int'(control);
            m_var  = int'(variant);
            m_lfsr = seed(m_var);
            m_wait = period(m_ctl % 4, int'(tone_freq));
        end else begin
`ifdef NOISE_TONE3_SYNC_EN
            if (m_ctl % 4 == 3) begin
                sh = tone3_out && !m_t3;
            end else
`endif
            if (enable) begin
                if (m_wait == 1) begin
                    sh = 1;
                    m_wait = period(m_ctl % 4, int'(tone_freq));
                end else begin
                    m_wait--;
                end
            end
            if (sh) m_lfsr = next_lfsr(m_lfsr, m_var, m_ctl >= 4);
        end
        m_strobe = sh;
        m_t3 = tone3_out;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out", 32'(out), 32'(m_lfsr & 1));
        chk("strobe", 32'(shift_strobe), 32'(m_strobe));
        chk("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
        if (rst_n) chk("lfsr_nonzero", 32'(dut.lfsr != 16'h0), 32'd1);
        cyc++;
        if (rnd_en) enable = ($urandom_range(0, 3) != 0);
        else        enable = (cyc % en_div == 0);
`ifdef NOISE_TONE3_SYNC_EN
        if (t3_toggle && (cyc % 7 == 0)) tone3_out = ~tone3_out;
`endif
    endtask

    task automatic wr(input logic [2:0] c, input logic [1:0] v);
        control = c; variant = v; control_wr = 1'b1;
        tick();
        control_wr = 1'b0;
    endtask

    // cycles until the next strobe, capped at limit
    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!shift_strobe && n < limit);
    endtask

    task automatic wait_out(input logic val, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (out !== val && n < limit);
    endtask

    initial begin
        int n, n2, shifts, rises, strobes;
        rst_n = 1'b0; enable = 1'b1; control_wr = 1'b0; control = 3'b000;
        variant = 2'b00; tone_freq = CB'(5); tone3_out = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_strobe", 32'(shift_strobe), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'h4000);
        chk("rst_cnt", 32'(dut.cnt), 32'd31);
        rst_n = 1'b1;
        tick();

        // white, variant 00
        wr(3'b100, 2'b00);
        wait_strobe(100, n);
        chk("white_first_strobe", n, 32);
        shifts = 1;
        while (!out && shifts < 30) begin
            wait_strobe(100, n);
            shifts++;
        end
        chk("white_first_high", shifts, 14);

        // periodic, variant 00: one high shift in 15 -> 480 enables
        wr(3'b000, 2'b00);
        wait_out(1'b1, 1000, n);
        wait_out(1'b0, 1000, n);
        wait_out(1'b1, 1000, n2);
        chk("periodic00_period", n + n2, 480);
        chk("periodic00_high_len", n, 32);

        // periodic, variant 01: first high after 15 shifts
        wr(3'b000, 2'b01);
        shifts = 0;
        while (!out && shifts < 30) begin
            wait_strobe(100, n);
            shifts++;
        end
        chk("periodic01_first_high", shifts, 15);

        // restart mid-stream
        wr(3'b100, 2'b10);
        repeat (20) tick();
        wr(3'b100, 2'b10);
        chk("restart_lfsr", 32'(dut.lfsr), 32'h4000);
        wait_strobe(100, n);
        chk("restart_first_strobe", n, 32);

        // write coinciding with the counter expiring
        n = 0;
        while (m_wait != 1 && n < 200) begin
            tick();
            n++;
        end
        wr(3'b100, 2'b00);
        chk("coinc_no_strobe", 32'(shift_strobe), 32'd0);
        wait_strobe(100, n);
        chk("coinc_next_strobe", n, 32);

`ifdef NOISE_TONE3_SYNC_EN
        // NF=11 follows tone3 rising edges, tone_freq ignored
        tone_freq = CB'(3);
        wr(3'b111, 2'b00);
        t3_toggle = 1'b1;
        rises = 0; strobes = 0;
        for (int i = 0; i < 300; i++) begin
            logic prev;
            prev = tone3_out;
            tick();
            if (shift_strobe) strobes++;
            if (!prev && tone3_out) rises++;
            if (i == 150) tone_freq = CB'(0);
        end
        t3_toggle = 1'b0;
        tone3_out = 1'b0;
        tick();
        if (shift_strobe) strobes++;
        chk("t3_one_per_rise", strobes, rises);
`else
        // NF=11 uses 2*tone_freq
        tone_freq = CB'(5);
        wr(3'b111, 2'b00);
        wait_strobe(100, n);
        chk("nf11_tf5_first", n, 10);
        wait_strobe(100, n);
        chk("nf11_tf5_interval", n, 10);
        tone_freq = CB'(0);
        wr(3'b111, 2'b00);
        wait_strobe(3000, n);
        chk("nf11_tf0_first", n, 2048);
        tone_freq = CB'(5);
        en_div = 16;
        wr(3'b111, 2'b00);
        wait_strobe(1000, n);
        wait_strobe(1000, n);
        chk("nf11_div16_interval", n, 160);
        en_div = 1;
`endif

        // reset mid-run with a simultaneous control write
        wr(3'b101, 2'b01);
        repeat (40) tick();
        rst_n = 1'b0; control_wr = 1'b1; control = 3'b111; variant = 2'b01;
        tick();
        rst_n = 1'b1; control_wr = 1'b0;
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_strobe", 32'(shift_strobe), 32'd0);
        chk("midrst_lfsr", 32'(dut.lfsr), 32'h4000);
        chk("midrst_cnt", 32'(dut.cnt), 32'd31);
        chk("midrst_ctl", 32'(dut.ctl_q), 32'd0);
        chk("midrst_var", 32'(dut.var_q), 32'd0);

        // randomized run against the model
        rnd_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tone3_out = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) tone_freq = CB'($urandom_range(0, 12));
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 59) == 0) begin
                control    = 3'($urandom_range(0, 7));
                variant    = 2'($urandom_range(0, 3));
                control_wr = 1'b1;
            end else begin
                control_wr = 1'b0;
            end
            tick();
        end
        rst_n = 1'b1; control_wr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
